// File: rtl/apb_master_if.sv
// Command/response port plus APB bus for the APB requester.
// The master modport is the requester's view; slave is the environment's view.
interface apb_master_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// APB requester: one command -> one SETUP/ACCESS transfer -> one response pulse.
// Wait states via PREADY; aborts with rsp_err after TIMEOUT low ACCESS edges.
module apb_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic          PCLK,
   input logic          PRESETn,
   apb_master_if.master bus
);
   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              timeout_hit;

   // Limit reached on this edge; a zero TIMEOUT never aborts.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_d  = SETUP;
               paddr_d  = bus.cmd_addr;
               pwrite_d = bus.cmd_write;
               if (bus.cmd_write) pwdata_d = bus.cmd_wdata;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            // Completion takes priority over the timeout on the same edge.
            if (bus.PREADY) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
            end else if (timeout_hit) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Bus controls decode straight from the state register.
   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.PSEL      = (state_q != IDLE);
   assign bus.PENABLE   = (state_q == ACCESS);
   assign bus.PADDR     = paddr_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-word commands from an internal command port into APB transfers on PSEL/PENABLE/PADDR/PWRITE/PWDATA. It supports completer wait states through PREADY and aborts with an error if PREADY stays low too long. Each transfer returns a one-cycle response with the read data or an error flag. The block sits between on-chip control logic and the APB memory/register completers on the same PCLK domain.

## Interface
- ADDR_W, 32, width of PADDR / cmd_addr
- DATA_W, 32, width of PWDATA / PRDATA / cmd_wdata / rsp_rdata
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on its rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse when a transfer ends
- rsp_rdata  out  DATA_W  captured PRDATA; 0 for writes and for aborted transfers
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout abort
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  completer ready; sampled only in ACCESS

## Operation
- States:
  - IDLE: PSEL=0, PENABLE=0, cmd_ready=1.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- IDLE -> SETUP: on cmd_valid && cmd_ready at a clock edge.
  - At that edge, register cmd_addr->PADDR, cmd_write->PWRITE and cmd_wdata->PWDATA.
  - For reads, PWDATA keeps its old value.
- SETUP -> ACCESS: unconditionally on the next edge. The wait counter clears to 0.
- ACCESS with PREADY=1: transfer completes.
  - Read: rsp_rdata <= PRDATA. Write: rsp_rdata <= 0.
  - rsp_err <= 0, rsp_valid <= 1, state -> IDLE.
- ACCESS with PREADY=0:
  - If TIMEOUT != 0 and the counter has reached TIMEOUT-1, abort: rsp_valid <= 1, rsp_err <= 1, rsp_rdata <= 0, state -> IDLE.
  - Otherwise increment the counter and stay in ACCESS. The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- Timeout length: with TIMEOUT=N, the abort is taken at the Nth consecutive PREADY-low edge in ACCESS.
- PREADY=1 on the same edge as the timeout limit: completion wins, no error.
- Address/data stability:
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle.
  - They keep their last values in IDLE and are not cleared.
- No back-to-back SETUP: every transfer returns to IDLE. cmd_valid is ignored outside IDLE.
- rsp_valid is high for exactly one cycle per accepted command. rsp_rdata and rsp_err hold until the next response.
- PRDATA is ignored outside a completing ACCESS edge, and during writes.
- Reset (PRESETn low, any time, including mid-transfer):
  - Immediately state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0. cmd_ready=1 while in IDLE.
  - An interrupted transfer produces no response.

## Timing
- Command accepted at edge E:
  - SETUP is visible in cycle E..E+1.
  - ACCESS is visible from E+1.
  - The earliest completion is at edge E+2.
- Completion at edge C: rsp_valid is high in cycle C..C+1, and cmd_ready is high in the same cycle.
  - A new command can be accepted at edge C+1, concurrent with the response pulse.
- Zero-wait throughput: one transfer per 3 cycles. Each PREADY-low ACCESS cycle adds 1 cycle of latency.
- All outputs are registered or decoded from the state register. There is no combinational path from PREADY/PRDATA or cmd_* to any output.

## Test plan
- Zero-wait write: cmd write, addr 0x10, data 0xDEADBEEF, PREADY=1.
  - Expected: PSEL rises 1 cycle after acceptance, PENABLE 1 cycle later.
  - rsp_valid pulses 3 cycles after acceptance with rsp_err=0 and rsp_rdata=0.
  - PADDR=0x10 and PWDATA=0xDEADBEEF are stable across SETUP and ACCESS.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, then high with PRDATA=0x12345678.
  - Expected: PENABLE high for 4 cycles; rsp_rdata=0x12345678, rsp_err=0.
- Timeout with TIMEOUT=4 and PREADY held low.
  - Expected: abort after 4 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; return to IDLE with PSEL=0.
- Timeout boundary: PREADY rises on the 4th low-counted edge.
  - Expected: normal completion, rsp_err=0.
- Back-to-back commands with cmd_valid held high and alternating write/read.
  - Expected: a new SETUP 1 cycle after each rsp_valid; no command is lost or duplicated; cmd_ready is low in SETUP and ACCESS.
- Reset asserted during ACCESS.
  - Expected: PSEL and PENABLE drop immediately without waiting for a clock edge; no rsp_valid.
  - After release, the first command completes normally.
